// File: rtl/baud_gen_frac.sv
// Fractional-N oversample tick generator with free-running TX bit phase and a
// re-alignable RX phase (mid-bit sample and bit-end strobes).
module baud_gen_frac #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div_int_in,
  input  logic [FRAC_W-1:0] div_frac_in,
  input  logic              div_load,
  input  logic              rx_restart,
  output logic              os_tick,
  output logic              tx_tick,
  output logic              rx_sample,
  output logic              rx_bit_end,
  output logic              div_pending
);

  localparam int     PH_W    = $clog2(OVERSAMPLE);
  localparam longint OS_RATE = longint'(BAUD_RATE) * longint'(OVERSAMPLE);
  localparam longint REM     = longint'(CLK_FREQ) % OS_RATE;

  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(longint'(CLK_FREQ) / OS_RATE);
  // Rounded remainder: (2*REM*2^FRAC_W + OS_RATE) / (2*OS_RATE).
  localparam logic [FRAC_W-1:0] DEF_FRAC =
    FRAC_W'(((REM << (FRAC_W + 1)) + OS_RATE) / (2 * OS_RATE));

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2 - 1);

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [DIV_W-1:0]  act_int_q, act_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [DIV_W-1:0]  sh_int_q, sh_int_d;
  logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
  logic              pend_q, pend_d;
  logic [PH_W-1:0]   tx_phase_q, tx_phase_d;
  logic [PH_W-1:0]   rx_phase_q, rx_phase_d;
  logic              os_tick_q, os_tick_d;
  logic              tx_tick_q, tx_tick_d;
  logic              rx_sample_q, rx_sample_d;
  logic              rx_bit_end_q, rx_bit_end_d;

  logic [DIV_W:0]    cur_last;
  logic              wrap;
  logic [DIV_W-1:0]  next_int;
  logic [FRAC_W-1:0] next_frac;
  logic [FRAC_W:0]   frac_sum;

  function automatic logic [DIV_W-1:0] clamp2(input logic [DIV_W-1:0] v);
    return (v < DIV_W'(2)) ? DIV_W'(2) : v;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    cur_last  = {1'b0, clamp2(act_int_q)} + {{DIV_W{1'b0}}, carry_q} - (DIV_W+1)'(1);
    wrap      = enable && ({1'b0, cnt_q} == cur_last);
    // A load coincident with the wrap bypasses the shadow and applies immediately.
    next_int  = div_load ? div_int_in  : (pend_q ? sh_int_q  : act_int_q);
    next_frac = div_load ? div_frac_in : (pend_q ? sh_frac_q : act_frac_q);
    frac_sum  = {1'b0, acc_q} + {1'b0, next_frac};

    cnt_d        = cnt_q;
    acc_d        = acc_q;
    carry_d      = carry_q;
    act_int_d    = act_int_q;
    act_frac_d   = act_frac_q;
    sh_int_d     = sh_int_q;
    sh_frac_d    = sh_frac_q;
    pend_d       = pend_q;
    tx_phase_d   = tx_phase_q;
    rx_phase_d   = rx_phase_q;
    os_tick_d    = 1'b0;
    tx_tick_d    = 1'b0;
    rx_sample_d  = 1'b0;
    rx_bit_end_d = 1'b0;

    if (div_load) begin
      sh_int_d  = div_int_in;
      sh_frac_d = div_frac_in;
      pend_d    = 1'b1;
    end

    if (!enable) begin
      cnt_d      = '0;
      acc_d      = '0;
      carry_d    = 1'b0;
      tx_phase_d = '0;
      rx_phase_d = '0;
    end else begin
      if (wrap) begin
        cnt_d               = '0;
        {carry_d, acc_d}    = frac_sum;
        act_int_d           = next_int;
        act_frac_d          = next_frac;
        pend_d              = 1'b0;
        tx_phase_d          = tx_phase_q + PH_W'(1);
        os_tick_d           = 1'b1;
        tx_tick_d           = (tx_phase_q == PH_LAST);
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end

      // Restart wins over a coincident wrap: that wrap never counts for RX.
      if (rx_restart) begin
        rx_phase_d = '0;
      end else if (wrap) begin
        rx_phase_d   = rx_phase_q + PH_W'(1);
        rx_sample_d  = (rx_phase_q == PH_MID);
        rx_bit_end_d = (rx_phase_q == PH_LAST);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the async reset
  // also restores the default divisor and drops any pending shadow value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      carry_q      <= 1'b0;
      act_int_q    <= DEF_INT;
      act_frac_q   <= DEF_FRAC;
      sh_int_q     <= DEF_INT;
      sh_frac_q    <= DEF_FRAC;
      pend_q       <= 1'b0;
      tx_phase_q   <= '0;
      rx_phase_q   <= '0;
      os_tick_q    <= 1'b0;
      tx_tick_q    <= 1'b0;
      rx_sample_q  <= 1'b0;
      rx_bit_end_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      carry_q      <= carry_d;
      act_int_q    <= act_int_d;
      act_frac_q   <= act_frac_d;
      sh_int_q     <= sh_int_d;
      sh_frac_q    <= sh_frac_d;
      pend_q       <= pend_d;
      tx_phase_q   <= tx_phase_d;
      rx_phase_q   <= rx_phase_d;
      os_tick_q    <= os_tick_d;
      tx_tick_q    <= tx_tick_d;
      rx_sample_q  <= rx_sample_d;
      rx_bit_end_q <= rx_bit_end_d;
    end
  end

  assign os_tick     = os_tick_q;
  assign tx_tick     = tx_tick_q;
  assign rx_sample   = rx_sample_q;
  assign rx_bit_end  = rx_bit_end_q;
  assign div_pending = pend_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: a 16x instance and a 4x instance share
// all inputs; expected cycle distances are hand-computed constants.
module tb_baud_gen_frac;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] div_int_in = '0;
  logic [3:0]  div_frac_in = '0;
  logic        div_load = 1'b0;
  logic        rx_restart = 1'b0;

  logic os16, tx16, rs16, be16, pd16;
  logic os4, tx4, rs4, be4, pd4;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  baud_gen_frac #(.OVERSAMPLE(16)) u_dut16 (
    .clk(clk), .reset(reset), .enable(enable),
    .div_int_in(div_int_in), .div_frac_in(div_frac_in), .div_load(div_load),
    .rx_restart(rx_restart),
    .os_tick(os16), .tx_tick(tx16), .rx_sample(rs16), .rx_bit_end(be16),
    .div_pending(pd16)
  );

  baud_gen_frac #(.OVERSAMPLE(4)) u_dut4 (
    .clk(clk), .reset(reset), .enable(enable),
    .div_int_in(div_int_in), .div_frac_in(div_frac_in), .div_load(div_load),
    .rx_restart(rx_restart),
    .os_tick(os4), .tx_tick(tx4), .rx_sample(rs4), .rx_bit_end(be4),
    .div_pending(pd4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return os16;
      1:       return tx16;
      2:       return rs16;
      3:       return be16;
      4:       return os4;
      5:       return tx4;
      6:       return rs4;
      default: return be4;
    endcase
  endfunction

  // Advance negedge by negedge until the selected strobe is seen.
  task automatic wait_pulse(input int w, input int limit, input string tag, output int t);
    int n;
    n = 0;
    t = -1;
    do begin
      @(negedge clk);
      n++;
    end while (sig(w) !== 1'b1 && n < limit);
    if (sig(w) !== 1'b1) check({tag, "_timeout"}, 0, 1);
    else t = cyc;
  endtask

  task automatic pulse_load(input int i, input int f);
    div_int_in  = 16'(i);
    div_frac_in = 4'(f);
    div_load    = 1'b1;
    @(negedge clk);
    div_load    = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k, t, t1, t2, prev, d, n55, nbad, ttx, ttx2, fs, fb;
    logic [9:0] quiet;

    // Reset state
    @(negedge clk);
    check("rst_outs", {os16, tx16, rs16, be16, pd16, os4, tx4, rs4, be4, pd4}, 0);
    repeat (2) @(negedge clk);

    // Default divisor 54 + 4/16
    reset = 1'b1;
    enable = 1'b1;
    k = cyc;
    wait_pulse(0, 200, "os_first", t);
    check("def_first_period", t - k, 54);
    @(negedge clk);
    check("os_width", os16, 0);
    prev = t; n55 = 0; nbad = 0; ttx = -1;
    for (int i = 0; i < 16; i++) begin
      wait_pulse(0, 200, "os_def", t);
      d = t - prev;
      if (d == 55) n55++;
      else if (d != 54) nbad++;
      if (tx16) ttx = t;
      prev = t;
    end
    check("def_period_54_55", nbad, 0);
    check("def_n55_of_16", n55, 4);
    wait_pulse(1, 2000, "tx_def", t);
    check("def_tx_period", t - ttx, 868);

    // Integer divisor 10, then mid-period reload to 5
    pulse_load(10, 0);
    wait_pulse(0, 200, "os10a", t1);
    wait_pulse(0, 200, "os10b", t2);
    check("int10_period", t2 - t1, 10);
    wait_pulse(0, 200, "os10c", t);
    repeat (3) @(negedge clk);
    pulse_load(5, 0);
    check("pend_set", pd16, 1);
    wait_pulse(0, 200, "os_old", t1);
    check("old_period_held", t1 - t, 10);
    check("pend_clr", pd16, 0);
    wait_pulse(0, 200, "os_new", t2);
    check("new_period5", t2 - t1, 5);

    // Reload coincident with a wrap
    wait_pulse(0, 200, "os5", t);
    repeat (4) @(negedge clk);
    pulse_load(10, 0);
    check("coinc_os", os16, 1);
    check("coinc_pend", pd16, 0);
    t1 = cyc;
    wait_pulse(0, 200, "os_coinc", t2);
    check("coinc_period10", t2 - t1, 10);

    // Clamp of int=0 and int=1
    pulse_load(0, 0);
    wait_pulse(0, 200, "os_c0a", t1);
    wait_pulse(0, 200, "os_c0b", t2);
    check("clamp0_period", t2 - t1, 2);
    pulse_load(1, 0);
    wait_pulse(0, 200, "os_c1a", t1);
    wait_pulse(0, 200, "os_c1b", t2);
    check("clamp1_period", t2 - t1, 2);

    // 7-cycle enable gap with a shadow load of 3 + 8/16 while idle
    enable = 1'b0;
    div_int_in = 16'd3;
    div_frac_in = 4'd8;
    div_load = 1'b1;
    quiet = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      div_load = 1'b0;
      quiet |= {os16, tx16, rs16, be16, 1'b0, os4, tx4, rs4, be4, 1'b0};
    end
    check("gap_quiet", quiet, 0);
    check("pend_idle", pd16, 1);
    enable = 1'b1;
    k = cyc;
    wait_pulse(0, 200, "os_reen", t);
    check("reen_first_period", t - k, 2);
    wait_pulse(0, 200, "os_f1", t1);
    check("frac_period_a", t1 - t, 3);
    wait_pulse(0, 200, "os_f2", t2);
    check("frac_period_b", t2 - t1, 4);
    for (int i = 0; i < 14; i++) wait_pulse(0, 200, "os_f", t2);
    check("frac_16_span", t2 - t, 56);

    // OVERSAMPLE=4 instance at int=3
    pulse_load(3, 0);
    wait_pulse(0, 200, "os3a", t);
    wait_pulse(0, 200, "os3b", t);
    wait_pulse(7, 200, "be4", t1);
    wait_pulse(6, 200, "rs4", t2);
    check("u4_end_to_sample", t2 - t1, 6);
    wait_pulse(5, 200, "tx4a", t1);
    wait_pulse(5, 200, "tx4b", t2);
    check("u4_tx_period", t2 - t1, 12);

    // RX restart away from a wrap
    wait_pulse(0, 200, "os_rx", t);
    rx_restart = 1'b1;
    @(negedge clk);
    rx_restart = 1'b0;
    fs = 0; fb = 0; ttx = -1;
    for (int n = 1; n <= 16; n++) begin
      wait_pulse(0, 200, "os_rx1", t);
      if (rs16 && fs == 0) fs = n;
      if (be16 && fb == 0) fb = n;
      if (tx16) ttx = t;
    end
    check("rx_first_sample", fs, 8);
    check("rx_first_end", fb, 16);

    // RX restart on the wrap that would have produced rx_sample
    for (int n = 0; n < 7; n++) wait_pulse(0, 200, "os_rx2", t);
    repeat (2) @(negedge clk);
    rx_restart = 1'b1;
    @(negedge clk);
    rx_restart = 1'b0;
    check("wrap_restart_os", os16, 1);
    check("wrap_restart_no_rx", {rs16, be16}, 0);
    fs = 0; ttx2 = -1;
    for (int n = 1; n <= 16; n++) begin
      wait_pulse(0, 200, "os_rx3", t);
      if (rs16 && fs == 0) fs = n;
      if (tx16) ttx2 = t;
    end
    check("wrap_rx_sample", fs, 8);
    check("tx_cadence_kept", (ttx2 - ttx) % 48, 0);

    // Asynchronous reset mid-period with a pending shadow
    wait_pulse(0, 200, "os_rst", t);
    pulse_load(7, 0);
    check("pend_before_rst", pd16, 1);
    reset = 1'b0;
    #1;
    check("rst_async_outs", {os16, tx16, rs16, be16, pd16, os4, tx4, rs4, be4, pd4}, 0);
    @(negedge clk);
    reset = 1'b1;
    k = cyc;
    wait_pulse(0, 200, "os_after_rst", t);
    check("rst_default_first", t - k, 54);
    check("rst_pend_dropped", pd16, 0);
    wait_pulse(0, 200, "os_after_rst2", t1);
    check("rst_default_second", t1 - t, 54);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
